clkgen_multi: RTL and testbench

Parametrised multi-channel clock-enable generator for the VGA/UART datapath. It replaces fixed per-function dividers with NCH independent channels, each runtime-programmable over a shared config port. Each channel produces a one-cycle tick enable and a registered square wave. A new divide ratio takes effect glitch-free, only at that channel's period boundary. Downstream logic (pixel pipeline, UART 16x oversampler, audio/timer tick) consumes tick as a clock enable on the single system clock.

---
 rtl/clkgen_multi_if.sv | 30 +++
 rtl/clkgen_multi.sv | 79 +++++++
 tb/tb_clkgen_multi.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clkgen_multi_if.sv
// Config/enable/status bundle for clkgen_multi.
// With CLKGEN_SYNC_EN defined the bundle also carries sync_req.
interface clkgen_multi_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned W   = 16
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [NCH-1:0] en;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] pending;
  logic           cfg_err;
`ifdef CLKGEN_SYNC_EN
  logic           sync_req;

  modport master (output cfg_we, cfg_ch, cfg_div, en, sync_req,
                  input  tick, sq, pending, cfg_err);
  modport slave  (input  cfg_we, cfg_ch, cfg_div, en, sync_req,
                  output tick, sq, pending, cfg_err);
`else
  modport master (output cfg_we, cfg_ch, cfg_div, en,
                  input  tick, sq, pending, cfg_err);
  modport slave  (input  cfg_we, cfg_ch, cfg_div, en,
                  output tick, sq, pending, cfg_err);
`endif
endinterface

// File: rtl/clkgen_multi.sv
// NCH-channel programmable clock-enable generator: per-channel tick and square wave.
// Optional macro CLKGEN_SYNC_EN adds a global phase-align request (sync_req).
module clkgen_multi #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned W       = 16,
  parameter int unsigned RST_DIV = 4
) (
  input logic            clk,
  input logic            rst,
  clkgen_multi_if.slave  bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [W-1:0]   div_q [NCH];
  logic [W-1:0]   nxt_q [NCH];
  logic [W-1:0]   cnt_q [NCH];
  logic [NCH-1:0] pend_q, tick_q, sq_q;
  logic           err_q;

  logic [W-1:0]   div_n [NCH];
  logic [W-1:0]   cnt_n [NCH];
  logic [W-1:0]   wdiv;
  logic [NCH-1:0] wr_hit, wrap, restart, apply;
  logic           sync;
  logic           ch_bad;

`ifdef CLKGEN_SYNC_EN
  assign sync = bus.sync_req;
`else
  assign sync = 1'b0;
`endif

  assign ch_bad = 32'(bus.cfg_ch) >= NCH;

  always_comb begin
    wdiv = (bus.cfg_div == '0) ? W'(1) : bus.cfg_div;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_hit[i]  = bus.cfg_we && (32'(bus.cfg_ch) == i);
      // sync and disable both force a phase restart and flush the shadow ratio
      restart[i] = sync || !bus.en[i];
      wrap[i]    = bus.en[i] && (cnt_q[i] == div_q[i] - W'(1));
      apply[i]   = pend_q[i] && (restart[i] || wrap[i]);
      div_n[i]   = apply[i] ? nxt_q[i] : div_q[i];
      cnt_n[i]   = (restart[i] || wrap[i]) ? '0 : cnt_q[i] + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        div_q[i] <= W'(RST_DIV);
        nxt_q[i] <= W'(RST_DIV);
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        div_q[i] <= div_n[i];
        cnt_q[i] <= cnt_n[i];
        // a write on the apply edge lands after the old shadow value was consumed
        if (wr_hit[i])
          nxt_q[i] <= wdiv;
        pend_q[i] <= wr_hit[i] || (pend_q[i] && !apply[i]);
        tick_q[i] <= wrap[i] && !sync;
        sq_q[i]   <= bus.en[i] && (cnt_n[i] >= (div_n[i] >> 1));
      end
      err_q <= bus.cfg_we && ch_bad;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.sq      = sq_q;
  assign bus.pending = pend_q;
  assign bus.cfg_err = err_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: directed literal pins plus randomized run vs a phase model.
// Exercises sync_req as well when CLKGEN_SYNC_EN is defined.
module tb_clkgen_multi;
  localparam int unsigned NCH = 3;
  localparam int unsigned W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  clkgen_multi_if #(.NCH(NCH), .W(W)) bus ();
  clkgen_multi #(.NCH(NCH), .W(W), .RST_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: each channel's period began at edge mstart; cnt = (k - mstart) mod div.
  int unsigned k;
  int unsigned mdiv [NCH];
  int unsigned mnxt [NCH];
  int unsigned mstart [NCH];
  bit          mpend [NCH];
  logic [NCH-1:0] etick, esq, epend;
  logic           eerr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NCH; i++) begin
      mdiv[i] = 4; mnxt[i] = 4; mstart[i] = 0; mpend[i] = 0;
    end
    etick = '0; esq = '0; epend = '0; eerr = 1'b0;
  endtask

  task automatic model_edge();
    bit sync_v;
    int unsigned ph;
`ifdef CLKGEN_SYNC_EN
    sync_v = bus.sync_req;
`else
    sync_v = 1'b0;
`endif
    k++;
    for (int i = 0; i < NCH; i++) begin
      ph = k - mstart[i];
      etick[i] = 1'b0;
      if (!bus.en[i] || sync_v) begin
        if (mpend[i]) begin mdiv[i] = mnxt[i]; mpend[i] = 0; end
        mstart[i] = k;
      end else if (ph % mdiv[i] == 0) begin
        etick[i] = 1'b1;
        if (mpend[i]) begin mdiv[i] = mnxt[i]; mpend[i] = 0; end
        mstart[i] = k;
      end
      if (bus.cfg_we && bus.cfg_ch == i) begin
        mnxt[i]  = (bus.cfg_div == 0) ? 1 : bus.cfg_div;
        mpend[i] = 1;
      end
      esq[i]   = bus.en[i] && (((k - mstart[i]) % mdiv[i]) >= mdiv[i] / 2);
      epend[i] = mpend[i];
    end
    eerr = bus.cfg_we && (bus.cfg_ch >= NCH);
  endtask

  task automatic check_all();
    chk("tick", 32'(bus.tick), 32'(etick));
    chk("sq", 32'(bus.sq), 32'(esq));
    chk("pending", 32'(bus.pending), 32'(epend));
    chk("cfg_err", 32'(bus.cfg_err), 32'(eerr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, 32'(bus.tick), 32'd0);
    chk({tag, "_sq"}, 32'(bus.sq), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
    chk({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
  endtask

  task automatic rand_inputs();
    bus.cfg_we  = ($urandom_range(0, 3) == 0);
    bus.cfg_ch  = 2'($urandom_range(0, 3));
    bus.cfg_div = 16'($urandom_range(0, 9));
    for (int i = 0; i < NCH; i++)
      bus.en[i] = ($urandom_range(0, 7) != 0);
`ifdef CLKGEN_SYNC_EN
    bus.sync_req = ($urandom_range(0, 19) == 0);
`endif
  endtask

  // Hand-computed expectations for edges 1..18 (bit e-1): RST_DIV=4,
  // ch1 rewritten to 6 on edge 2 (applies at edge 4), bad channel 3 written on edge 17.
  logic [17:0] pin_tick0, pin_tick1, pin_sq0, pin_sq1, pin_pend1, pin_err;

  initial begin
    pin_tick0 = 18'h08888;
    pin_tick1 = 18'h08208;
    pin_sq0   = 18'h26666;
    pin_sq1   = 18'h071C6;
    pin_pend1 = 18'h00006;
    pin_err   = 18'h10000;

    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.en = '0;
`ifdef CLKGEN_SYNC_EN
    bus.sync_req = 1'b0;
`endif
    model_reset();
    #7;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    bus.en = '1;

    for (int e = 1; e <= 18; e++) begin
      bus.cfg_we  = (e == 2) || (e == 17);
      bus.cfg_ch  = (e == 2) ? 2'd1 : 2'd3;
      bus.cfg_div = 16'd6;
      step();
      chk("pin_tick0", 32'(bus.tick[0]), 32'(pin_tick0[e-1]));
      chk("pin_tick1", 32'(bus.tick[1]), 32'(pin_tick1[e-1]));
      chk("pin_sq0", 32'(bus.sq[0]), 32'(pin_sq0[e-1]));
      chk("pin_sq1", 32'(bus.sq[1]), 32'(pin_sq1[e-1]));
      chk("pin_pend1", 32'(bus.pending[1]), 32'(pin_pend1[e-1]));
      chk("pin_err", 32'(bus.cfg_err), 32'(pin_err[e-1]));
    end
    bus.cfg_we = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      step();
    end

    // asynchronous reset in the middle of a cycle discards everything
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 1000; n++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
